// File: rtl/mmio_responder_if.sv
// ----------------------------------------------------------------------------
// mmio_responder_if
// Bus bundle shared by the CPU (master) and memory-mapped responders (slave).
// Signals:
//   addr    - bus address (master -> slave)
//   in_val  - write data (master -> slave)
//   get     - read strobe (master -> slave)
//   set     - write strobe (master -> slave)
//   out     - registered read data, zero when the slave is not selected
//   hit     - registered; high the cycle after a get inside the slave window
// ----------------------------------------------------------------------------
interface mmio_responder_if #(
   parameter int WORD_SIZE = 16
);
   logic [WORD_SIZE-1:0] addr;
   logic [WORD_SIZE-1:0] in_val;
   logic                 get;
   logic                 set;
   logic [WORD_SIZE-1:0] out;
   logic                 hit;

   modport master (output addr, output in_val, output get, output set,
                   input out, input hit);
   modport slave  (input addr, input in_val, input get, input set,
                   output out, output hit);
endinterface

// File: rtl/mmio_responder.sv
// ----------------------------------------------------------------------------
// mmio_responder
// Memory-mapped I/O responder occupying an 8-word window at BASE. Provides a
// display register, synchronized switches, a prescaled 32-bit timer with a
// coherent LO/HI read, two scratch registers and a clear-on-read status word.
// Read data is zero whenever the window is not selected, so the CPU read mux
// can OR this output with data_memory's.
//
// Ports:
//   mclk        - system clock, rising edge
//   reset_n     - asynchronous active-low reset
//   bus         - slave side of addr/in_val/get/set/out/hit bus
//   switches    - asynchronous board switches (two-flop synchronized)
//   display_val - DISPLAY register contents for ssd_driver
//   irq         - timer compare interrupt (only with MMIO_TIMER_IRQ_EN)
//
// Build option: define MMIO_TIMER_IRQ_EN to turn offset 5 into COMPARE and
// add the irq output; otherwise offset 5 is SCRATCH1.
// ----------------------------------------------------------------------------
module mmio_responder #(
   parameter int                   WORD_SIZE = 16,
   parameter logic [WORD_SIZE-1:0] BASE      = 16'hFFF8,
   parameter int                   SW_WIDTH  = 8
) (
   input  logic                 mclk,
   input  logic                 reset_n,
   mmio_responder_if.slave      bus,
   input  logic [SW_WIDTH-1:0]  switches,
`ifdef MMIO_TIMER_IRQ_EN
   output logic                 irq,
`endif
   output logic [WORD_SIZE-1:0] display_val
);

   localparam logic [WORD_SIZE-1:0] ZERO_W = {WORD_SIZE{1'b0}};
   localparam logic [WORD_SIZE-1:0] ONE_W  = {{(WORD_SIZE-1){1'b0}}, 1'b1};

   logic                 sel_s, rd_s, wr_s, tick_s, wrap_s, disp_wr_s, st_rd_s;
   logic [2:0]           off_s;

   logic [WORD_SIZE-1:0] display_q, display_d;
   logic [WORD_SIZE-1:0] scratch0_q, scratch0_d;
   // SCRATCH1 in the default build, COMPARE when the timer IRQ is built in
   logic [WORD_SIZE-1:0] reg5_q, reg5_d;
   logic [WORD_SIZE-1:0] prescale_q, prescale_d;
   logic [WORD_SIZE-1:0] pcnt_q, pcnt_d;
   logic [31:0]          timer_q, timer_d;
   logic [15:0]          hi_latch_q, hi_latch_d;
   logic                 st_wrap_q, st_wrap_d;
   logic                 st_disp_q, st_disp_d;
   logic [SW_WIDTH-1:0]  sw_sync1_q, sw_sync2_q;
   logic [WORD_SIZE-1:0] out_q, out_d;
   logic                 hit_q, hit_d;
`ifdef MMIO_TIMER_IRQ_EN
   logic                 irq_q, irq_d;
`endif

   assign sel_s   = (bus.addr[WORD_SIZE-1:3] == BASE[WORD_SIZE-1:3]);
   assign off_s   = bus.addr[2:0];
   assign rd_s    = bus.get && sel_s;
   assign wr_s    = bus.set && sel_s;
   // A PRESCALE write restarts the period, so it also suppresses this tick
   assign tick_s  = (pcnt_q == prescale_q) && !(wr_s && (off_s == 3'd7));
   assign wrap_s  = tick_s && (timer_q == 32'hFFFF_FFFF);
   assign disp_wr_s = wr_s && (off_s == 3'd0);
   assign st_rd_s   = rd_s && (off_s == 3'd6);

   // Next-state for registers, prescaler/timer, status and read port
   always_comb begin
      display_d  = display_q;
      scratch0_d = scratch0_q;
      reg5_d     = reg5_q;
      prescale_d = prescale_q;
      pcnt_d     = pcnt_q;
      timer_d    = timer_q;
      hi_latch_d = hi_latch_q;
      st_wrap_d  = st_wrap_q;
      st_disp_d  = st_disp_q;
      out_d      = ZERO_W;
      hit_d      = 1'b0;

      // Prescale counter: 0..PRESCALE, restarted by a PRESCALE write
      if (wr_s && (off_s == 3'd7)) begin
         pcnt_d = ZERO_W;
      end else if (tick_s) begin
         pcnt_d = ZERO_W;
      end else begin
         pcnt_d = pcnt_q + ONE_W;
      end

      if (tick_s) begin
         timer_d = timer_q + 32'd1;
      end else begin
         timer_d = timer_q;
      end

      // Read path sees pre-write register values (read-before-write)
      if (rd_s) begin
         hit_d = 1'b1;
         case (off_s)
            3'd0: out_d = display_q;
            3'd1: out_d = {{(WORD_SIZE-SW_WIDTH){1'b0}}, sw_sync2_q};
            3'd2: begin
               out_d      = WORD_SIZE'(timer_q[15:0]);
               hi_latch_d = timer_q[31:16];
            end
            3'd3: out_d = WORD_SIZE'(hi_latch_q);
            3'd4: out_d = scratch0_q;
            3'd5: out_d = reg5_q;
            3'd6: out_d = {{(WORD_SIZE-2){1'b0}}, st_disp_q, st_wrap_q};
            3'd7: out_d = prescale_q;
            default: out_d = ZERO_W;
         endcase
      end else begin
         out_d = ZERO_W;
         hit_d = 1'b0;
      end

      // Writes to read-only offsets (1, 2, 3, 6) fall through and are ignored
      if (wr_s) begin
         case (off_s)
            3'd0: display_d  = bus.in_val;
            3'd4: scratch0_d = bus.in_val;
            3'd5: reg5_d     = bus.in_val;
            3'd7: prescale_d = bus.in_val;
            default: display_d = display_q;
         endcase
      end else begin
         display_d = display_q;
      end

      // Status: a set event in the same cycle beats clear-on-read
      if (wrap_s) begin
         st_wrap_d = 1'b1;
      end else if (st_rd_s) begin
         st_wrap_d = 1'b0;
      end else begin
         st_wrap_d = st_wrap_q;
      end

      if (disp_wr_s) begin
         st_disp_d = 1'b1;
      end else if (st_rd_s) begin
         st_disp_d = 1'b0;
      end else begin
         st_disp_d = st_disp_q;
      end
   end

`ifdef MMIO_TIMER_IRQ_EN
   // Compare interrupt: set when a tick lands TIMER[15:0] on COMPARE
   always_comb begin
      irq_d = irq_q;
      if (wr_s && (off_s == 3'd5)) begin
         irq_d = 1'b0;
      end else if (tick_s && (WORD_SIZE'(timer_d[15:0]) == reg5_q)) begin
         irq_d = 1'b1;
      end else begin
         irq_d = irq_q;
      end
   end
`endif

   // State registers, asynchronously cleared
   always_ff @(posedge mclk or negedge reset_n) begin
      if (!reset_n) begin
         display_q  <= ZERO_W;
         scratch0_q <= ZERO_W;
         reg5_q     <= ZERO_W;
         prescale_q <= ZERO_W;
         pcnt_q     <= ZERO_W;
         timer_q    <= 32'd0;
         hi_latch_q <= 16'd0;
         st_wrap_q  <= 1'b0;
         st_disp_q  <= 1'b0;
         sw_sync1_q <= {SW_WIDTH{1'b0}};
         sw_sync2_q <= {SW_WIDTH{1'b0}};
         out_q      <= ZERO_W;
         hit_q      <= 1'b0;
`ifdef MMIO_TIMER_IRQ_EN
         irq_q      <= 1'b0;
`endif
      end else begin
         display_q  <= display_d;
         scratch0_q <= scratch0_d;
         reg5_q     <= reg5_d;
         prescale_q <= prescale_d;
         pcnt_q     <= pcnt_d;
         timer_q    <= timer_d;
         hi_latch_q <= hi_latch_d;
         st_wrap_q  <= st_wrap_d;
         st_disp_q  <= st_disp_d;
         sw_sync1_q <= switches;
         sw_sync2_q <= sw_sync1_q;
         out_q      <= out_d;
         hit_q      <= hit_d;
`ifdef MMIO_TIMER_IRQ_EN
         irq_q      <= irq_d;
`endif
      end
   end

   assign bus.out     = out_q;
   assign bus.hit     = hit_q;
   assign display_val = display_q;
`ifdef MMIO_TIMER_IRQ_EN
   assign irq         = irq_q;
`endif

endmodule

// File: tb/tb_mmio_responder.sv
// ----------------------------------------------------------------------------
// tb_mmio_responder
// Table-driven directed bench for mmio_responder plus hand sequences for
// switch synchronization, reset mid-read, prescaled timer and timer wrap.
// Inputs change on the falling edge; outputs are compared on the falling edge.
// ----------------------------------------------------------------------------
module tb_mmio_responder;

   logic        mclk;
   logic        reset_n;
   logic [7:0]  switches;
   logic [15:0] display_val;
`ifdef MMIO_TIMER_IRQ_EN
   logic        irq;
`endif

   int total = 0;
   int bad   = 0;

   mmio_responder_if #(.WORD_SIZE(16)) bus ();

   mmio_responder #(.WORD_SIZE(16), .BASE(16'hFFF8), .SW_WIDTH(8)) dut (
      .mclk        (mclk),
      .reset_n     (reset_n),
      .bus         (bus),
      .switches    (switches),
`ifdef MMIO_TIMER_IRQ_EN
      .irq         (irq),
`endif
      .display_val (display_val)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   typedef struct {
      logic        g;
      logic        s;
      logic [15:0] a;
      logic [15:0] v;
      logic [15:0] eo;
      logic        eh;
      logic [15:0] ed;
   } vec_t;

   localparam int NV = 18;
   vec_t vecs [NV];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Drive one bus cycle at the falling edge and return at the next falling edge
   task automatic step(input logic g, input logic s, input logic [15:0] a, input logic [15:0] v);
      bus.get    = g;
      bus.set    = s;
      bus.addr   = a;
      bus.in_val = v;
      @(posedge mclk);
      @(negedge mclk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000);
   endtask

   initial begin
      //                g     s     addr      in_val    exp_out   hit   display
      vecs[0]  = '{1'b1, 1'b0, 16'hFFF8, 16'h0000, 16'h0000, 1'b1, 16'h0000};
      vecs[1]  = '{1'b1, 1'b0, 16'h0003, 16'h0000, 16'h0000, 1'b0, 16'h0000};
      vecs[2]  = '{1'b0, 1'b1, 16'hFFF8, 16'h1234, 16'h0000, 1'b0, 16'h1234};
      vecs[3]  = '{1'b1, 1'b0, 16'hFFF8, 16'h0000, 16'h1234, 1'b1, 16'h1234};
      vecs[4]  = '{1'b1, 1'b0, 16'hFFFE, 16'h0000, 16'h0002, 1'b1, 16'h1234};
      vecs[5]  = '{1'b1, 1'b0, 16'hFFFE, 16'h0000, 16'h0000, 1'b1, 16'h1234};
      vecs[6]  = '{1'b1, 1'b1, 16'hFFFC, 16'hBEEF, 16'h0000, 1'b1, 16'h1234};
      vecs[7]  = '{1'b1, 1'b0, 16'hFFFC, 16'h0000, 16'hBEEF, 1'b1, 16'h1234};
      vecs[8]  = '{1'b0, 1'b1, 16'hFFFD, 16'h5A5A, 16'h0000, 1'b0, 16'h1234};
      vecs[9]  = '{1'b1, 1'b0, 16'hFFFD, 16'h0000, 16'h5A5A, 1'b1, 16'h1234};
      vecs[10] = '{1'b0, 1'b1, 16'hFFF9, 16'hFFFF, 16'h0000, 1'b0, 16'h1234};
      vecs[11] = '{1'b1, 1'b0, 16'hFFF9, 16'h0000, 16'h0000, 1'b1, 16'h1234};
      vecs[12] = '{1'b0, 1'b1, 16'h00F8, 16'h7777, 16'h0000, 1'b0, 16'h1234};
      vecs[13] = '{1'b1, 1'b0, 16'hFFF8, 16'h0000, 16'h1234, 1'b1, 16'h1234};
      vecs[14] = '{1'b0, 1'b0, 16'hFFF8, 16'h0000, 16'h0000, 1'b0, 16'h1234};
      vecs[15] = '{1'b0, 1'b1, 16'hFFFB, 16'h1111, 16'h0000, 1'b0, 16'h1234};
      vecs[16] = '{1'b1, 1'b0, 16'hFFFB, 16'h0000, 16'h0000, 1'b1, 16'h1234};
      vecs[17] = '{1'b1, 1'b0, 16'hFFFE, 16'h0000, 16'h0000, 1'b1, 16'h1234};

      bus.get = 1'b0; bus.set = 1'b0; bus.addr = 16'h0000; bus.in_val = 16'h0000;
      switches = 8'h00;
      reset_n  = 1'b0;
      @(negedge mclk);
      @(negedge mclk);
      chk("reset_out", {16'h0, bus.out}, 32'h0);
      chk("reset_hit", {31'h0, bus.hit}, 32'h0);
      chk("reset_disp", {16'h0, display_val}, 32'h0);
      reset_n = 1'b1;
      @(negedge mclk);

      // Table-driven single-cycle transactions
      for (int i = 0; i < NV; i++) begin
         step(vecs[i].g, vecs[i].s, vecs[i].a, vecs[i].v);
         chk($sformatf("vec%0d_out", i), {16'h0, bus.out}, {16'h0, vecs[i].eo});
         chk($sformatf("vec%0d_hit", i), {31'h0, bus.hit}, {31'h0, vecs[i].eh});
         chk($sformatf("vec%0d_disp", i), {16'h0, display_val}, {16'h0, vecs[i].ed});
      end

      // Switch synchronizer: value visible only two cycles after the change
      switches = 8'hA5;
      step(1'b1, 1'b0, 16'hFFF9, 16'h0000);
      chk("sw_lat1", {16'h0, bus.out}, 32'h0000);
      step(1'b1, 1'b0, 16'hFFF9, 16'h0000);
      chk("sw_lat2", {16'h0, bus.out}, 32'h0000);
      step(1'b1, 1'b0, 16'hFFF9, 16'h0000);
      chk("sw_val", {16'h0, bus.out}, 32'h00A5);

      // Reset in the middle of a read result drops it immediately
      bus.get = 1'b1; bus.set = 1'b0; bus.addr = 16'hFFF8;
      @(posedge mclk);
      #1;
      chk("midrd_hit", {31'h0, bus.hit}, 32'h1);
      chk("midrd_out", {16'h0, bus.out}, 32'h1234);
      reset_n = 1'b0;
      #1;
      chk("rst_out_now", {16'h0, bus.out}, 32'h0);
      chk("rst_hit_now", {31'h0, bus.hit}, 32'h0);
      chk("rst_disp_now", {16'h0, display_val}, 32'h0);
      bus.get = 1'b0;
      @(negedge mclk);
      @(negedge mclk);
      reset_n = 1'b1;

      // Prescaler: PRESCALE=3 written right after reset, ticks every 4 cycles
      step(1'b0, 1'b1, 16'hFFFF, 16'h0003);
      idle(40);
      step(1'b1, 1'b0, 16'hFFFA, 16'h0000);
      chk("tmr_lo_p3", {16'h0, bus.out}, 32'h000A);
      step(1'b0, 1'b1, 16'hFFFA, 16'hFFFF);
      step(1'b1, 1'b0, 16'hFFFA, 16'h0000);
      chk("tmr_lo_ro", {16'h0, bus.out}, 32'h000A);
      step(1'b1, 1'b0, 16'hFFFB, 16'h0000);
      chk("tmr_hi_p3", {16'h0, bus.out}, 32'h0000);
      step(1'b1, 1'b0, 16'hFFFF, 16'h0000);
      chk("prescale_rd", {16'h0, bus.out}, 32'h0003);

      // Timer wrap: deposit all-ones, PRESCALE=0 ticks on the next edge
      step(1'b0, 1'b1, 16'hFFFF, 16'h0000);
      force dut.timer_q = 32'hFFFF_FFFF;
      #1;
      release dut.timer_q;
      idle(1);
      step(1'b1, 1'b0, 16'hFFFA, 16'h0000);
      chk("wrap_lo", {16'h0, bus.out}, 32'h0000);
      step(1'b1, 1'b0, 16'hFFFB, 16'h0000);
      chk("wrap_hi", {16'h0, bus.out}, 32'h0000);
      step(1'b1, 1'b0, 16'hFFFE, 16'h0000);
      chk("wrap_status", {16'h0, bus.out}, 32'h0001);
      step(1'b1, 1'b0, 16'hFFFE, 16'h0000);
      chk("wrap_status_clr", {16'h0, bus.out}, 32'h0000);
      idle(1);
      chk("idle_out", {16'h0, bus.out}, 32'h0000);
      chk("idle_hit", {31'h0, bus.hit}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mmio_responder.md
Name: mmio_responder

Overview:
- Memory-mapped I/O responder on the same addr/val/get/set/out bus that data_memory serves.
- Claims a fixed 8-word address window and answers reads and writes there; data_memory answers everywhere else.
- Provides a display register for ssd_driver, synchronized switch input, a 32-bit cycle timer, scratch registers and a sticky status word.
- Output is forced to zero when not selected, so the CPU-side read mux is a plain OR with data_memory's output.

Parameters:
- WORD_SIZE, 16, bus data and address width.
- BASE, 16'hFFF8, window base address; must be 8-aligned (low 3 bits zero).
- SW_WIDTH, 8, width of the switch input.

Ports:
- mclk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- addr  input  WORD_SIZE  bus address.
- in_val  input  WORD_SIZE  write data.
- get  input  1  read strobe.
- set  input  1  write strobe.
- out  output  WORD_SIZE  registered read data; zero when not selected.
- hit  output  1  registered; high the cycle after a get inside the window.
- switches  input  SW_WIDTH  asynchronous board switches.
- display_val  output  WORD_SIZE  DISPLAY register contents, feeds ssd_driver.

Behaviour:
- sel = (addr[WORD_SIZE-1:3] == BASE[WORD_SIZE-1:3]). Offset = addr[2:0].
- Register map:
  - 0 DISPLAY: read/write.
  - 1 SWITCH: read-only; zero-extended, two-flop synchronized switches.
  - 2 TIMER_LO: read-only; reading it snapshots TIMER[31:16] into HI_LATCH.
  - 3 TIMER_HI: read-only; returns HI_LATCH.
  - 4 SCRATCH0: read/write.
  - 5 SCRATCH1: read/write.
  - 6 STATUS: bit0 = timer-wrapped sticky, bit1 = DISPLAY written since last STATUS read; other bits zero. Read clears both bits.
  - 7 PRESCALE: read/write; TIMER increments once every PRESCALE+1 cycles.
- Writes: when set && sel, a write to a read/write offset updates that register at the clock edge. Writes to read-only offsets are ignored.
- Reads: when get && sel, out <= register value and hit <= 1 at the edge, so data is valid exactly 1 cycle after the get.
  - Otherwise out <= 0 and hit <= 0.
  - No hold of a stale value.
- Simultaneous get and set to the same offset: read-before-write; out returns the pre-write value and the register takes in_val.
- STATUS clear-on-read collides with a set event in the same cycle: the set event wins and the bit stays 1.
- Prescaler and timer:
  - An internal 16-bit prescale counter counts 0..PRESCALE, then wraps to 0 and pulses a tick.
  - On each tick, TIMER (32 bits) increments.
  - TIMER wraps from 0xFFFFFFFF to 0 and sets the STATUS bit0 sticky.
  - A PRESCALE write resets the prescale counter to 0.
- HI_LATCH changes only on a TIMER_LO read, so the LO-then-HI read sequence is coherent.
- Reset (reset_n low, asynchronous):
  - out=0, hit=0.
  - DISPLAY, SCRATCH0/1, PRESCALE, TIMER, HI_LATCH, STATUS, prescale counter and sync flops all cleared.
  - Reset mid-transaction drops any pending read result, and out is 0 immediately.
- display_val always mirrors DISPLAY combinationally from the register.

Optional Feature:
- Macro MMIO_TIMER_IRQ_EN.
- When defined:
  - Adds output irq (1 bit) plus a read/write register at offset 5 replacing SCRATCH1: COMPARE.
  - irq is set (registered) on the cycle TIMER[15:0] == COMPARE after a tick.
  - irq is cleared by any write to COMPARE or by reset.
- When undefined: no irq port, and offset 5 is SCRATCH1 exactly as above.

Test Plan:
- Reset, then get at 16'hFFF8 → out=0, hit=1 one cycle later; get at 16'h0003 → out=0, hit=0.
- set 16'hFFF8 = 16'h1234; next cycle get 16'hFFF8 → out=16'h1234 one cycle later; display_val=16'h1234; STATUS read returns 16'h0002; a second STATUS read returns 16'h0000.
- Same-cycle get+set on 16'hFFFC: old 16'h0000 then write 16'hBEEF → out=16'h0000; next get → 16'hBEEF.
- PRESCALE=3, run 40 cycles from the PRESCALE write, read TIMER_LO → 16'h000A; write 16'hFFFF to offset 2 → ignored, value unchanged.
- Force TIMER to 32'hFFFFFFFF via the bench (hierarchical deposit), PRESCALE=0, one tick → TIMER_LO=0, TIMER_HI=0, STATUS bit0=1, cleared after read.
- switches=8'hA5 → SWITCH read returns 16'h00A5 no earlier than 2 cycles after the change; assert reset_n low mid-read → out drops to 0 immediately.
